// File: rtl/uart_motor_dispatch_if.sv
// UART byte link between the byte-level UART PHY and the motor command dispatcher.
// master: the UART PHY side (delivers received bytes, owns the transmitter busy flag).
// slave : the dispatcher side (consumes received bytes, requests transmissions).
interface uart_motor_dispatch_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (
    output rx_valid,
    output rx_data,
    input  tx_start,
    input  tx_data,
    output tx_busy
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output tx_start,
    output tx_data,
    input  tx_busy
  );
endinterface

// File: rtl/uart_motor_dispatch.sv
// UART command dispatcher for a bank of stepper-motor channels.
// Parses 6-byte command packets (H, B1..B4, CK), loads per-channel divider/steps/direction,
// answers each packet with one ack/nak byte and answers a 1-byte status request with a
// pending/limit-switch snapshot. Partial packets are dropped after an idle timeout.
//
// Receive FSM
//   state   | meaning
//   RX_IDLE | waiting for a header byte (or a status request)
//   RX_PAY  | collecting the four payload bytes, B1 first
//   RX_CK   | waiting for the checksum byte
//   RX_EVAL | one cycle: check packet, load channel, queue reply
//
// Transmit FSM
//   state   | meaning
//   TX_IDLE | nothing to send
//   TX_WAIT | byte selected, waiting for the transmitter to go idle
//   TX_FIRE | tx_start high for this one cycle
//   TX_HOLD | give the transmitter up to two cycles to raise tx_busy
module uart_motor_dispatch #(
  parameter int NUM_CH      = 10,
  parameter int DIV_W       = 16,
  parameter int STEP_W      = 11,
  parameter int TIMEOUT_CYC = 262143
) (
  input  logic                     CLOCK_25,
  input  logic                     rst,
  uart_motor_dispatch_if.slave     uart,
  input  logic [NUM_CH-1:0]        ch_active,
  input  logic [NUM_CH-1:0]        term,
  output logic [NUM_CH*DIV_W-1:0]  cmd_div,
  output logic [NUM_CH*STEP_W-1:0] cmd_steps,
  output logic [NUM_CH-1:0]        cmd_dir,
  output logic [NUM_CH-1:0]        pending,
  output logic                     timeout_err
);

  localparam int P  = (NUM_CH + 4) / 5;  // status bytes per field
  localparam int NB = 2 * P;             // bytes in a status reply
  localparam int SW = 5 * P;             // padded snapshot width
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_PAY, RX_CK, RX_EVAL} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_FIRE, TX_HOLD} tx_state_t;

  // receive path
  rx_state_t       rx_state_q, rx_state_d;
  logic [7:0]      hdr_q, hdr_d;
  logic [31:0]     w_q, w_d;
  logic [7:0]      ck_q, ck_d;
  logic [1:0]      pay_cnt_q, pay_cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            tmo_err_q, tmo_err_d;
  logic            stat_req;
  logic            eval;

  // channel registers
  logic [DIV_W-1:0]  div_q   [NUM_CH];
  logic [DIV_W-1:0]  div_d   [NUM_CH];
  logic [STEP_W-1:0] steps_q [NUM_CH];
  logic [STEP_W-1:0] steps_d [NUM_CH];
  logic [NUM_CH-1:0] dir_q, dir_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] act_q;
  logic [NUM_CH-1:0] rise;
  logic              ch_ok, sel_pend, ck_ok, accept;

  // transmit path
  tx_state_t       tx_state_q, tx_state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [1:0]      hold_cnt_q, hold_cnt_d;
  logic            rep_vld_q, rep_vld_d;
  logic [7:0]      rep_q, rep_d;
  logic            stat_vld_q, stat_vld_d;
  logic [2:0]      stat_idx_q, stat_idx_d;
  logic            cur_stat_q, cur_stat_d;
  logic [SW-1:0]   pend_snap_q, pend_snap_d;
  logic [SW-1:0]   term_snap_q, term_snap_d;
  logic [7:0]      stat_byte;
  logic            pick;

  // Receive FSM and idle-timeout counter: next state
  always_comb begin
    rx_state_d = rx_state_q;
    hdr_d      = hdr_q;
    w_d        = w_q;
    ck_d       = ck_q;
    pay_cnt_d  = pay_cnt_q;
    tmo_d      = tmo_q;
    tmo_err_d  = 1'b0;
    stat_req   = 1'b0;
    eval       = 1'b0;

    if (uart.rx_valid) begin
      tmo_d = TW'(TIMEOUT_CYC);
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - 1'b1;
    end

    case (rx_state_q)
      RX_IDLE: begin
        if (uart.rx_valid) begin
          if (uart.rx_data[3:0] == 4'hF) begin
            stat_req = 1'b1;
          end else begin
            hdr_d      = uart.rx_data;
            pay_cnt_d  = 2'd0;
            rx_state_d = RX_PAY;
          end
        end
      end
      RX_PAY: begin
        if (uart.rx_valid) begin
          // shift in from the top so B1 ends up in the low byte
          w_d       = {uart.rx_data, w_q[31:8]};
          pay_cnt_d = pay_cnt_q + 2'd1;
          if (pay_cnt_q == 2'd3) rx_state_d = RX_CK;
        end else if (tmo_q == TW'(1)) begin
          rx_state_d = RX_IDLE;
          tmo_err_d  = 1'b1;
        end
      end
      RX_CK: begin
        if (uart.rx_valid) begin
          ck_d       = uart.rx_data;
          rx_state_d = RX_EVAL;
        end else if (tmo_q == TW'(1)) begin
          rx_state_d = RX_IDLE;
          tmo_err_d  = 1'b1;
        end
      end
      RX_EVAL: begin
        eval       = 1'b1;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receive FSM state register
  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      hdr_q      <= '0;
      w_q        <= '0;
      ck_q       <= '0;
      pay_cnt_q  <= '0;
      tmo_q      <= '0;
      tmo_err_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      hdr_q      <= hdr_d;
      w_q        <= w_d;
      ck_q       <= ck_d;
      pay_cnt_q  <= pay_cnt_d;
      tmo_q      <= tmo_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  // Packet check: channel in range, checksum, and channel free
  always_comb begin
    ch_ok    = 1'b0;
    sel_pend = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hdr_q[3:0] == 4'(c)) begin
        ch_ok    = 1'b1;
        sel_pend = pend_q[c];
      end
    end
  end

  assign ck_ok  = (ck_q == (hdr_q ^ w_q[7:0] ^ w_q[15:8] ^ w_q[23:16] ^ w_q[31:24]));
  assign accept = ck_ok & ch_ok & ~sel_pend;
  assign rise   = ch_active & ~act_q;

  // Channel registers: a take clears the slot, a same-cycle accept overrides it
  always_comb begin
    div_d   = div_q;
    steps_d = steps_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rise[c]) begin
        pend_d[c]  = 1'b0;
        steps_d[c] = '0;
      end
      if (eval && accept && (hdr_q[3:0] == 4'(c))) begin
        div_d[c]   = w_q[DIV_W-1:0];
        steps_d[c] = w_q[DIV_W+STEP_W-1:DIV_W];
        dir_d[c]   = w_q[31];
        pend_d[c]  = 1'b1;
      end
    end
  end

  // Channel register bank and ch_active edge history
  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        div_q[c]   <= '0;
        steps_q[c] <= '0;
      end
      dir_q  <= '0;
      pend_q <= '0;
      act_q  <= '0;
    end else begin
      div_q   <= div_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      act_q   <= ch_active;
    end
  end

  // Status byte k: pending field for k < P, limit-switch field after that
  always_comb begin
    stat_byte = '0;
    for (int k = 0; k < P; k++) begin
      if (stat_idx_q == 3'(k))     stat_byte = {3'(k), pend_snap_q[5*k +: 5]};
      if (stat_idx_q == 3'(P + k)) stat_byte = {3'(P + k), term_snap_q[5*k +: 5]};
    end
  end

  // Transmit FSM, reply latch and status latch: next state
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    hold_cnt_d  = hold_cnt_q;
    rep_vld_d   = rep_vld_q;
    rep_d       = rep_q;
    stat_vld_d  = stat_vld_q;
    stat_idx_d  = stat_idx_q;
    cur_stat_d  = cur_stat_q;
    pend_snap_d = pend_snap_q;
    term_snap_d = term_snap_q;
    pick        = 1'b0;

    case (tx_state_q)
      TX_IDLE: pick = 1'b1;
      TX_WAIT: if (!uart.tx_busy) tx_state_d = TX_FIRE;
      TX_FIRE: begin
        tx_state_d = TX_HOLD;
        hold_cnt_d = 2'd0;
      end
      TX_HOLD: begin
        if (uart.tx_busy || (hold_cnt_q == 2'd1)) pick = 1'b1;
        else hold_cnt_d = hold_cnt_q + 2'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // at every byte boundary a pending reply goes ahead of the status sequence
    if (pick) begin
      tx_state_d = TX_IDLE;
      cur_stat_d = 1'b0;
      if (rep_vld_q) begin
        tx_data_d  = rep_q;
        rep_vld_d  = 1'b0;
        tx_state_d = TX_WAIT;
      end else if (stat_vld_q) begin
        tx_data_d  = stat_byte;
        cur_stat_d = 1'b1;
        tx_state_d = TX_WAIT;
        if (stat_idx_q == 3'(NB - 1)) begin
          stat_vld_d = 1'b0;
          stat_idx_d = 3'd0;
        end else begin
          stat_idx_d = stat_idx_q + 3'd1;
        end
      end
    end

    // newest reply replaces one that has not been picked yet
    if (eval) begin
      rep_vld_d = 1'b1;
      rep_d     = {(accept ? 4'hA : 4'hE), hdr_q[3:0]};
    end

    if (stat_req && !stat_vld_q && !(cur_stat_q && (tx_state_q != TX_IDLE))) begin
      stat_vld_d  = 1'b1;
      stat_idx_d  = 3'd0;
      pend_snap_d = SW'(pend_q);
      term_snap_d = SW'(~term);
    end
  end

  // Transmit FSM state register and latches
  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_data_q   <= '0;
      hold_cnt_q  <= '0;
      rep_vld_q   <= 1'b0;
      rep_q       <= '0;
      stat_vld_q  <= 1'b0;
      stat_idx_q  <= '0;
      cur_stat_q  <= 1'b0;
      pend_snap_q <= '0;
      term_snap_q <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_vld_q   <= rep_vld_d;
      rep_q       <= rep_d;
      stat_vld_q  <= stat_vld_d;
      stat_idx_q  <= stat_idx_d;
      cur_stat_q  <= cur_stat_d;
      pend_snap_q <= pend_snap_d;
      term_snap_q <= term_snap_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign cmd_div[c*DIV_W +: DIV_W]      = div_q[c];
    assign cmd_steps[c*STEP_W +: STEP_W] = steps_q[c];
  end

  // payload bits between the step field and the direction bit carry no meaning
  if (DIV_W + STEP_W < 31) begin : g_spare
    logic unused_w;
    assign unused_w = ^w_q[30:DIV_W+STEP_W];
  end

  assign cmd_dir       = dir_q;
  assign pending       = pend_q;
  assign timeout_err   = tmo_err_q;
  assign uart.tx_start = (tx_state_q == TX_FIRE);
  assign uart.tx_data  = tx_data_q;

endmodule

// File: doc/uart_motor_dispatch.md
UART_MOTOR_DISPATCH -- requirements
Module: uart_motor_dispatch

Interface
REQ-001 Parameter NUM_CH, default 10, number of motor channels; legal range 1..15.
REQ-002 Parameter DIV_W, default 16, step-divider width per channel.
REQ-003 Parameter STEP_W, default 11, step-count width per channel; DIV_W+STEP_W SHALL be at most 31.
REQ-004 Parameter TIMEOUT_CYC, default 262143, number of idle clocks after which a partial packet is discarded.
REQ-005 CLOCK_25  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-008 rx_data  in  8  received UART byte.
REQ-009 ch_active  in  NUM_CH  per-channel motor-controller busy flag.
REQ-010 term  in  NUM_CH  per-channel limit switch, active-low.
REQ-011 cmd_div  out  NUM_CH*DIV_W  per-channel divider; channel c occupies slice [c*DIV_W +: DIV_W].
REQ-012 cmd_steps  out  NUM_CH*STEP_W  per-channel step count, sliced the same way.
REQ-013 cmd_dir  out  NUM_CH  per-channel direction.
REQ-014 pending  out  NUM_CH  command loaded but not yet taken by the controller.
REQ-015 tx_start  out  1  one-cycle transmit strobe.
REQ-016 tx_data  out  8  byte to transmit; valid while tx_start is high.
REQ-017 tx_busy  in  1  transmitter busy.
REQ-018 timeout_err  out  1  one-cycle pulse when a partial packet is discarded.

Function
REQ-019 Command packet is 6 bytes: H, B1, B2, B3, B4, CK.
- H[3:0] = channel number; H[7:4] is ignored.
- W = {B4,B3,B2,B1}, B1 is the LSB.
- CK SHALL equal H^B1^B2^B3^B4.
REQ-020 A status request is a single byte with H[3:0]=4'hF, recognised only in RX_IDLE; the receive FSM stays in RX_IDLE.
REQ-021 Receive FSM: RX_IDLE -> RX_PAY (4 bytes counted) -> RX_CK -> evaluate -> RX_IDLE; the FSM advances only on rx_valid.
REQ-022 Evaluate occurs in the cycle after CK is received. Accept only if all three hold: CK matches, channel < NUM_CH, and pending[ch]==0. Anything else is a reject.
REQ-023 On accept, from the next clock:
- cmd_div[ch] = W[DIV_W-1:0]
- cmd_steps[ch] = W[DIV_W+STEP_W-1:DIV_W]
- cmd_dir[ch] = W[31]
- pending[ch] = 1
- other channels are unchanged.
REQ-024 Taking a command: a rising edge of ch_active[c] (registered 0 -> 1) SHALL clear pending[c] and cmd_steps[c] on the next clock.
REQ-025 If an accept and a ch_active rising edge hit the same channel in the same cycle, the accept wins: pending=1 and the new steps are kept.
REQ-026 Every evaluated packet queues exactly one reply byte: 8'hA0|ch on accept, 8'hE0|ch on reject.
REQ-027 A status request queues 2*P bytes, where P=ceil(NUM_CH/5).
- Byte k (k<P) = {k[2:0], pending[5k+4:5k]}.
- Byte P+k = {(P+k)[2:0], ~term[5k+4:5k]}.
- Bits for channels at or above NUM_CH read 0.
- Snapshot values are captured in the cycle the request is recognised.
REQ-028 Transmit FSM: TX_IDLE -> TX_WAIT (tx_busy==0) -> TX_FIRE (tx_start=1 for 1 cycle) -> TX_HOLD (until tx_busy seen 1, or 2 cycles elapse) -> next byte or TX_IDLE.
REQ-029 Queueing:
- One reply latch and one status latch.
- If both are set, the reply is sent first.
- A status request arriving while a status sequence is queued or in flight is dropped.
- A new reply overwrites an unsent reply.
REQ-030 Timeout:
- The counter reloads to TIMEOUT_CYC on every rx_valid and decrements otherwise.
- On reaching 0 while not in RX_IDLE: return to RX_IDLE, pulse timeout_err, queue no reply.
- If rx_valid coincides with expiry, the byte is processed and the counter reloads.
REQ-031 A 4'hF header byte inside a packet is treated as ordinary payload data.

Reset
REQ-032 While rst=1 at a clock edge, the following SHALL be forced to 0 on that edge and hold: cmd_div, cmd_steps, cmd_dir, pending, tx_start, tx_data, timeout_err, latches, the ch_active edge registers, and the timeout counter.
REQ-033 While rst=1, both FSMs SHALL be in IDLE; an in-flight packet or transmission is abandoned without output.
REQ-034 rx_valid SHALL be ignored in any cycle where rst=1.

Verification
REQ-035 NUM_CH=10, bytes 03 FF 00 64 80 18 -> ch3 div=0x00FF, steps=100, dir=1, pending[3]=1; tx 0xA3.
REQ-036 Same packet again with ch_active[3] still 0 -> reject, tx 0xE3, ch3 registers unchanged; then ch_active[3] 0 -> 1 -> pending[3]=0, steps[3]=0.
REQ-037 Packet with CK=0x19 -> tx 0xE3, no register change; header 0x0C (channel 12 >= 10) with valid CK -> tx 0xEC.
REQ-038 pending=10'h021, term=10'h3FE, byte 0x0F -> tx 0x01, 0x21, 0x41, 0x60 in order, each only after tx_busy has dropped.
REQ-039 Bytes 05 11 sent, then TIMEOUT_CYC idle clocks -> timeout_err pulses once, no tx; the next 6-byte packet to ch5 is accepted normally.
REQ-040 rst asserted after B2 of a packet -> all outputs 0; post-reset full packet accepted; rx_valid on the exact expiry cycle -> no timeout_err.
